truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Upstream stimulus/capture stage for the 5-input minterm-simplification logic blocks.
//  On start, drives every input combination 0..2^N_IN-1 onto the target's a..e inputs.
//  Captures the target's single output into a truth-table register and compares it against EXPECTED.
//  Reports pass/fail, the mismatch count and the first failing index.
// PARAMETERS
//  N_IN      5             number of target inputs; vec_out[N_IN-1] drives a (MSB), vec_out[0] drives e
//  SETTLE    1             extra cycles each vector is held before sampling (0..15)
//  EXPECTED  32'hCFC89F7F  golden truth table; bit i = required output for input index i
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         synchronous reset, active-low
//  start          in   1         begin a sweep; accepted only in IDLE
//  dut_out        in   1         output of the block under sweep
//  vec_out        out  N_IN      current input vector to the target
//  busy           out  1         high from the cycle after start is accepted until done
//  done           out  1         1-cycle pulse when a sweep finishes
//  pass           out  1         1 if mismatch_cnt==0; valid from done, held until next start
//  mismatch_cnt   out  N_IN+1    number of indices where dut_out != EXPECTED[i]
//  first_fail     out  N_IN      lowest failing index (0 if none)
//  table_q        out  2^N_IN    captured truth table
// BEHAVIOUR
//  - Reset: rst_n low at a clk edge forces the following. State=IDLE. All outputs are 0,
//    except pass, which is 1.
//  - Reset wins over start in the same cycle. Reset mid-sweep aborts the sweep with no done pulse.
//  - FSM states: IDLE, DRIVE, DONE.
//  - IDLE->DRIVE on start.
//    - On the accepting edge: vec_out<=0, settle cnt<=0, busy<=1.
//    - On the same edge, clear table_q, mismatch_cnt, first_fail and pass to 0.
//  - DRIVE: cnt increments each cycle. When cnt==SETTLE:
//    - table_q[vec_out]<=dut_out.
//    - If dut_out!=EXPECTED[vec_out]: mismatch_cnt++.
//    - If this is the first mismatch of the sweep: first_fail<=vec_out.
//    - If vec_out==2^N_IN-1: go to DONE. Otherwise vec_out++ and cnt<=0.
//  - Each vector is held exactly SETTLE+1 cycles. dut_out is sampled in the last of those cycles.
//  - DONE (1 cycle): done=1, busy=0, pass=(mismatch_cnt==0), vec_out holds the last index; then IDLE.
//  - Latency: done is high exactly 2^N_IN*(SETTLE+1)+1 cycles after the start-accept edge.
//  - start while busy or in DONE: ignored, with no effect on the sweep.
//  - Results (pass, mismatch_cnt, first_fail, table_q) hold until the next accepted start.
//  - mismatch_cnt is N_IN+1 bits wide, so an all-fail sweep reports 2^N_IN without wrap.
//  - vec_out wraps never: the sweep terminates at 2^N_IN-1.
// CONFIGURATION
//  SWEEP_STOP_ON_FAIL_EN defined:
//    - The sweep terminates at the first mismatch: DONE is entered on the next edge instead of incrementing.
//    - Result: mismatch_cnt=1, first_fail=failing index, pass=0.
//    - table_q bits above the failing index remain 0.
//    - Latency becomes (first_fail+1)*(SETTLE+1)+1.
//  SWEEP_STOP_ON_FAIL_EN undefined: always a full sweep, as described above.
// TESTING
//  1. dut_out = combinational model of EXPECTED, default params, pulse start
//     -> done at cycle 65; pass=1; mismatch_cnt=0; table_q=32'hCFC89F7F.
//  2. Model with index 7 inverted -> pass=0, mismatch_cnt=1, first_fail=7, table_q=32'hCFC89FFF.
//  3. dut_out tied 0 -> mismatch_cnt=22, first_fail=0, table_q=0.
//     With SWEEP_STOP_ON_FAIL_EN: done 3 cycles after accept, mismatch_cnt=1.
//  4. start re-pulsed at cycle 10 and cycle 64 of a sweep
//     -> no restart; done still at cycle 65; results equal to scenario 1.
//  5. rst_n low at cycle 20 mid-sweep
//     -> next cycle busy=0, vec_out=0, pass=1, no done; a new start then gives scenario-1 results.
//  6. SETTLE=0, golden model -> each vector held 1 cycle; done at cycle 33; pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input combination 0..2^N_IN-1 onto a target
// block, captures its single output into a truth table and compares it against
// the EXPECTED golden table, reporting pass, mismatch count and first failing index.
// Optional feature macro: SWEEP_STOP_ON_FAIL_EN (terminate the sweep at the first mismatch).
module truth_table_sweeper #(
    parameter int unsigned          N_IN     = 5,
    parameter int unsigned          SETTLE   = 1,
    parameter logic [2**N_IN-1:0]   EXPECTED = 32'hCFC89F7F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   table_q
);

    localparam int unsigned      DEPTH      = 2**N_IN;
    localparam logic [N_IN-1:0]  LAST_IDX   = N_IN'(DEPTH - 1);
    localparam logic [N_IN-1:0]  VEC_ONE    = N_IN'(1);
    localparam logic [N_IN:0]    CNT_ONE    = (N_IN+1)'(1);
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        sample;
    logic        miss;
    logic        sweep_end;

    // State register; reset returns the sweeper to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the per-cycle sample/mismatch/end qualifiers.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        miss       = 1'b0;
        sweep_end  = 1'b0;

        sample = (state == DRIVE) && (cnt == SETTLE_CNT);
        miss   = sample && (dut_out != EXPECTED[vec_out]);
`ifdef SWEEP_STOP_ON_FAIL_EN
        sweep_end = sample && ((vec_out == LAST_IDX) || miss);
`else
        sweep_end = sample && (vec_out == LAST_IDX);
`endif

        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (sweep_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: vector/settle counters, capture, and result registers.
    // done/busy/pass are updated on the edge leaving DONE so the pulse lands
    // one cycle after the final sample, matching the documented latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_out      <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b1;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            table_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out      <= '0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        table_q      <= '0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        table_q[vec_out] <= dut_out;
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt + CNT_ONE;
                            if (mismatch_cnt == '0) begin
                                first_fail <= vec_out;
                            end
                        end
                        if (!sweep_end) begin
                            vec_out <= vec_out + VEC_ONE;
                            cnt     <= '0;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (mismatch_cnt == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
